fifo_write_arbiter: RTL and testbench
=====================================

Name: fifo_write_arbiter

Overview:
- Shares one FIFO write port among N_REQ requesters using round-robin arbitration with bounded bursts.
- Sits in front of the FIFO control/RAM pair and drives its write strobe and write data.
- Consumes the FIFO's full flag and back-pressures the granted requester through a per-requester ack.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- DATA_WIDTH, 8, width of each write word.
- MAX_BURST, 4, maximum words accepted per grant before forced release (1..15).

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- req  input  N_REQ  per-requester write request; held high while the requester has a word on req_data.
- req_data  input  N_REQ*DATA_WIDTH  packed words; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- fifo_full  input  1  full flag from FIFO control.
- grant  output  N_REQ  one-hot registered grant, or all zero.
- ack  output  N_REQ  word from requester i accepted this cycle; requester advances its data on ack.
- write  output  1  write strobe to FIFO control.
- w_data  output  DATA_WIDTH  data of granted requester; zero when no grant.
- busy  output  1  high while in BURST.

Behaviour:
- Reset (async): state=IDLE, grant=0, rr_ptr=0, burst_cnt=0. While reset is high: write=0, ack=0, w_data=0, busy=0.
- State machine: IDLE and BURST.
- IDLE:
  - If any req bit is high, select the first set bit searching upward from rr_ptr, wrapping modulo N_REQ.
  - Register that bit into grant, clear burst_cnt, go to BURST next edge.
  - If no req is high, remain in IDLE with grant=0.
- BURST, with g = the granted index:
  - write = req[g] & ~fifo_full, combinational from the registered grant; ack[g]=write; all other ack bits 0.
  - w_data = req_data slice g.
  - Each write increments burst_cnt (width ceil(log2(MAX_BURST+1))).
  - Release to IDLE at the next edge when either:
    - req[g]=0 while sampled in BURST, or
    - a write occurs with burst_cnt==MAX_BURST-1.
  - On release: grant<=0, rr_ptr<=(g+1) mod N_REQ.
  - fifo_full=1 with req[g]=1: stall. Hold grant, no write, no ack, burst_cnt unchanged, no timeout.
- Latency:
  - req sampled high at edge t (arbiter idle) -> grant visible after t; first write in that same cycle if not full.
  - Each burst is followed by exactly one IDLE cycle (arbitration bubble). Sustained throughput is MAX_BURST words per MAX_BURST+1 cycles.
- Fairness:
  - A requester that just released gets lowest priority in the next arbitration.
  - With all requesters active, grants go 0,1,2,...,N_REQ-1,0,...
- Requests that rise while another requester holds the grant wait for the next IDLE cycle. No preemption.
- Requests that drop mid-burst end the burst with burst_cnt < MAX_BURST. This is legal; no error signalled.
- Reset mid-burst: grant, write and ack drop asynchronously. Words already acked stay written. rr_ptr returns to 0.
- Never more than one ack bit high. write is never high when fifo_full=1 or when grant=0.

Test Plan:
- Reset then idle: reset=1 with req=4'b1111 -> grant=0, write=0. After release, first grant is 4'b0001 exactly one edge later.
- Single requester stream: req[2]=1 continuously, fifo_full=0.
  - Required: write high for 4 consecutive cycles with ack[2], then 1 bubble cycle, then the next burst.
  - w_data equals req_data slice 2 throughout each burst.
- Round-robin rotation: req=4'b1111 held for 25 cycles with MAX_BURST=4.
  - Required: grant sequence 0001,0010,0100,1000,0001.
  - Each grant produces 4 writes; total 20 writes in 25 cycles.
- Early release: req[1]=1 for 2 acked words, then req[1]=0, with req[3]=1 pending.
  - Required: burst ends after 2 writes, IDLE for 1 cycle, then grant=4'b1000.
- Full stall: mid-burst of requester 0 after 1 write, assert fifo_full for 5 cycles.
  - Required: write=0 and ack=0 for those 5 cycles, grant stays 0001.
  - After fifo_full drops, exactly 3 more writes occur, then release.
- Async reset mid-burst: assert reset between clock edges during requester 2's burst.
  - Required: grant, write and ack go to 0 before the next edge.
  - After deassertion, arbitration restarts from requester 0.

Source files
------------

// File: rtl/fifo_write_arbiter_if.sv
// Requester-side write bus for the shared FIFO write port: requests/data in,
// grant/ack back-pressure out, plus the FIFO strobe, data and full flag.
interface fifo_write_arbiter_if #(
   parameter int N_REQ      = 4,
   parameter int DATA_WIDTH = 8
);
   logic [N_REQ-1:0]            req;
   logic [N_REQ*DATA_WIDTH-1:0] req_data;
   logic                        fifo_full;
   logic [N_REQ-1:0]            grant;
   logic [N_REQ-1:0]            ack;
   logic                        write;
   logic [DATA_WIDTH-1:0]       w_data;
   logic                        busy;

   modport slave (
      input  req, req_data, fifo_full,
      output grant, ack, write, w_data, busy
   );

   modport master (
      output req, req_data, fifo_full,
      input  grant, ack, write, w_data, busy
   );
endinterface

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among N_REQ requesters,
// with bursts capped at MAX_BURST words and a one-cycle arbitration bubble.
module fifo_write_arbiter #(
   parameter int N_REQ      = 4,
   parameter int DATA_WIDTH = 8,
   parameter int MAX_BURST  = 4
) (
   input logic                 clk,
   input logic                 reset,
   fifo_write_arbiter_if.slave bus
);

   localparam int CNT_W = $clog2(MAX_BURST + 1);
   localparam int IDX_W = $clog2(N_REQ);

   typedef enum logic {IDLE, BURST} state_t;

   state_t                state;
   logic [N_REQ-1:0]      grant_q;
   logic [IDX_W-1:0]      g_idx;
   logic [IDX_W-1:0]      rr_ptr;
   logic [CNT_W-1:0]      burst_cnt;

   logic                  pick_vld;
   logic [IDX_W-1:0]      pick_idx;
   logic [IDX_W:0]        sum;
   logic                  g_req;
   logic                  wr;
   logic [DATA_WIDTH-1:0] w_data_mux;

   // Descending scan so the requester closest above rr_ptr is written last and wins.
   always_comb begin
      pick_vld = 1'b0;
      pick_idx = '0;
      sum      = '0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         sum = {1'b0, rr_ptr} + (IDX_W + 1)'(k);
         if (sum >= (IDX_W + 1)'(N_REQ)) sum = sum - (IDX_W + 1)'(N_REQ);
         if (bus.req[sum[IDX_W-1:0]]) begin
            pick_vld = 1'b1;
            pick_idx = sum[IDX_W-1:0];
         end
      end
   end

   assign g_req = bus.req[g_idx];
   assign wr    = (state == BURST) & g_req & ~bus.fifo_full;

   always_comb begin
      w_data_mux = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (grant_q[i]) w_data_mux = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         grant_q   <= '0;
         g_idx     <= '0;
         rr_ptr    <= '0;
         burst_cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (pick_vld) begin
                  state     <= BURST;
                  grant_q   <= N_REQ'(1) << pick_idx;
                  g_idx     <= pick_idx;
                  burst_cnt <= '0;
               end
            end
            BURST: begin
               // A dropped request or the last allowed word both end the burst.
               if (!g_req || (wr && burst_cnt == CNT_W'(MAX_BURST - 1))) begin
                  state   <= IDLE;
                  grant_q <= '0;
                  rr_ptr  <= (g_idx == IDX_W'(N_REQ - 1)) ? '0 : g_idx + 1'b1;
               end else if (wr) begin
                  burst_cnt <= burst_cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.grant  = grant_q;
   assign bus.ack    = wr ? grant_q : '0;
   assign bus.write  = wr;
   assign bus.w_data = w_data_mux;
   assign bus.busy   = (state == BURST);

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Randomized and directed bench for fifo_write_arbiter, compared cycle by cycle
// against a transaction-level model of owner / words-in-burst / next-priority.
module tb_fifo_write_arbiter;

   localparam int N_REQ      = 4;
   localparam int DATA_WIDTH = 8;
   localparam int MAX_BURST  = 4;
   localparam int OUT_W      = 2*N_REQ + 1 + DATA_WIDTH + 1;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   fifo_write_arbiter_if #(.N_REQ(N_REQ), .DATA_WIDTH(DATA_WIDTH)) bus();

   fifo_write_arbiter #(
      .N_REQ(N_REQ), .DATA_WIDTH(DATA_WIDTH), .MAX_BURST(MAX_BURST)
   ) dut (
      .clk(clk),
      .reset(rst),
      .bus(bus.slave)
   );

   int vectors     = 0;
   int miscompares = 0;

   // Model: who owns the port (-1 none), words written this burst, priority start.
   int m_owner;
   int m_cnt;
   int m_ptr;

   function automatic logic req_bit(int i);
      logic [N_REQ-1:0] t;
      t = bus.req >> i;
      return t[0];
   endfunction

   function automatic logic [OUT_W-1:0] model_out();
      logic [N_REQ-1:0]      g;
      logic [N_REQ-1:0]      a;
      logic                  w;
      logic [DATA_WIDTH-1:0] d;
      logic                  b;
      g = '0; a = '0; w = 1'b0; d = '0; b = 1'b0;
      if (m_owner >= 0 && !rst) begin
         g = N_REQ'(1) << m_owner;
         b = 1'b1;
         d = DATA_WIDTH'(bus.req_data >> (m_owner * DATA_WIDTH));
         w = req_bit(m_owner) && !bus.fifo_full;
         if (w) a = g;
      end
      return {g, a, w, d, b};
   endfunction

   task automatic model_reset();
      m_owner = -1;
      m_cnt   = 0;
      m_ptr   = 0;
   endtask

   task automatic model_edge();
      if (rst) begin
         model_reset();
      end else if (m_owner < 0) begin
         for (int k = 0; k < N_REQ; k++) begin
            int i;
            i = (m_ptr + k) % N_REQ;
            if (req_bit(i)) begin
               m_owner = i;
               m_cnt   = 0;
               break;
            end
         end
      end else begin
         if (!req_bit(m_owner)) begin
            m_ptr   = (m_owner + 1) % N_REQ;
            m_owner = -1;
         end else if (!bus.fifo_full) begin
            m_cnt++;
            if (m_cnt == MAX_BURST) begin
               m_ptr   = (m_owner + 1) % N_REQ;
               m_owner = -1;
            end
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic rand_data();
      for (int i = 0; i < N_REQ; i++) bus.req_data[i*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'($urandom);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      model_reset();
      bus.req = '0;
      bus.fifo_full = 1'b0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      model_reset();
      bus.req = 4'b1111;
      bus.fifo_full = 1'b0;
      rand_data();
      @(negedge clk);
      vectors++;
      if (bus.grant !== 4'b0000 || bus.write !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_hold: grant=%b write=%b, want 0000/0", bus.grant, bus.write);
      end
      vectors++;
      if ({bus.grant, bus.ack, bus.write, bus.w_data, bus.busy} !== model_out()) begin
         miscompares++;
         $display("FAIL reset_outputs: got %h want %h", {bus.grant, bus.ack, bus.write, bus.w_data, bus.busy}, model_out());
      end
      tick();
      rst = 1'b0;
      @(negedge clk);
      vectors++;
      if (bus.grant !== 4'b0000) begin
         miscompares++;
         $display("FAIL reset_release_idle: grant=%b want 0000", bus.grant);
      end
      tick();
      @(negedge clk);
      vectors++;
      if (bus.grant !== 4'b0001) begin
         miscompares++;
         $display("FAIL reset_first_grant: grant=%b want 0001", bus.grant);
      end
      tick();
   endtask

   task automatic test_single_stream();
      do_reset();
      bus.req = 4'b0100;
      for (int c = 0; c < 15; c++) begin
         rand_data();
         @(negedge clk);
         vectors++;
         if ({bus.grant, bus.ack, bus.write, bus.w_data, bus.busy} !== model_out()) begin
            miscompares++;
            $display("FAIL single_stream cyc%0d: got %h want %h", c, {bus.grant, bus.ack, bus.write, bus.w_data, bus.busy}, model_out());
         end
         vectors++;
         if (bus.write !== ((c % 5) != 0)) begin
            miscompares++;
            $display("FAIL single_stream_pattern cyc%0d: write=%b want %b", c, bus.write, (c % 5) != 0);
         end
         tick();
      end
   endtask

   task automatic test_round_robin();
      logic [N_REQ-1:0] seen[$];
      logic [N_REQ-1:0] prev;
      logic [N_REQ-1:0] exp_seq[5];
      int writes;
      exp_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      writes = 0;
      prev = '0;
      do_reset();
      bus.req = 4'b1111;
      for (int c = 0; c < 25; c++) begin
         rand_data();
         @(negedge clk);
         vectors++;
         if ({bus.grant, bus.ack, bus.write, bus.w_data, bus.busy} !== model_out()) begin
            miscompares++;
            $display("FAIL round_robin cyc%0d: got %h want %h", c, {bus.grant, bus.ack, bus.write, bus.w_data, bus.busy}, model_out());
         end
         if (bus.write === 1'b1) writes++;
         if (bus.grant !== '0 && prev === '0) seen.push_back(bus.grant);
         prev = bus.grant;
         tick();
      end
      vectors++;
      if (writes != 20) begin
         miscompares++;
         $display("FAIL rr_write_count: got %0d want 20", writes);
      end
      vectors++;
      if (seen.size() != 5) begin
         miscompares++;
         $display("FAIL rr_grant_count: got %0d want 5", seen.size());
      end else begin
         for (int i = 0; i < 5; i++) begin
            vectors++;
            if (seen[i] !== exp_seq[i]) begin
               miscompares++;
               $display("FAIL rr_grant_seq[%0d]: got %b want %b", i, seen[i], exp_seq[i]);
            end
         end
      end
   endtask

   task automatic test_early_release();
      logic [N_REQ-1:0] g[6];
      int writes;
      writes = 0;
      do_reset();
      for (int c = 0; c < 6; c++) begin
         bus.req = (c < 3) ? 4'b1010 : 4'b1000;
         rand_data();
         @(negedge clk);
         vectors++;
         if ({bus.grant, bus.ack, bus.write, bus.w_data, bus.busy} !== model_out()) begin
            miscompares++;
            $display("FAIL early_release cyc%0d: got %h want %h", c, {bus.grant, bus.ack, bus.write, bus.w_data, bus.busy}, model_out());
         end
         g[c] = bus.grant;
         if (bus.write === 1'b1 && bus.grant === 4'b0010) writes++;
         tick();
      end
      vectors++;
      if (writes != 2) begin
         miscompares++;
         $display("FAIL early_release_writes: got %0d want 2", writes);
      end
      vectors++;
      if (g[4] !== 4'b0000 || g[5] !== 4'b1000) begin
         miscompares++;
         $display("FAIL early_release_handoff: got %b,%b want 0000,1000", g[4], g[5]);
      end
   endtask

   task automatic test_full_stall();
      int writes;
      writes = 0;
      do_reset();
      bus.req = 4'b0001;
      for (int c = 0; c < 12; c++) begin
         bus.fifo_full = (c >= 2 && c <= 6);
         rand_data();
         @(negedge clk);
         vectors++;
         if ({bus.grant, bus.ack, bus.write, bus.w_data, bus.busy} !== model_out()) begin
            miscompares++;
            $display("FAIL full_stall cyc%0d: got %h want %h", c, {bus.grant, bus.ack, bus.write, bus.w_data, bus.busy}, model_out());
         end
         if (c >= 2 && c <= 6) begin
            vectors++;
            if (bus.write !== 1'b0 || bus.ack !== 4'b0000 || bus.grant !== 4'b0001) begin
               miscompares++;
               $display("FAIL full_stall_hold cyc%0d: write=%b ack=%b grant=%b want 0/0000/0001", c, bus.write, bus.ack, bus.grant);
            end
         end
         if (c >= 7 && c <= 10 && bus.write === 1'b1) writes++;
         if (c == 10) begin
            vectors++;
            if (bus.grant !== 4'b0000) begin
               miscompares++;
               $display("FAIL full_stall_release: grant=%b want 0000", bus.grant);
            end
         end
         tick();
      end
      bus.fifo_full = 1'b0;
      vectors++;
      if (writes != 3) begin
         miscompares++;
         $display("FAIL full_stall_resume_writes: got %0d want 3", writes);
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      bus.req = 4'b0100;
      for (int c = 0; c < 3; c++) begin
         rand_data();
         @(negedge clk);
         vectors++;
         if ({bus.grant, bus.ack, bus.write, bus.w_data, bus.busy} !== model_out()) begin
            miscompares++;
            $display("FAIL async_pre cyc%0d: got %h want %h", c, {bus.grant, bus.ack, bus.write, bus.w_data, bus.busy}, model_out());
         end
         if (c < 2) tick();
      end
      #2;
      rst = 1'b1;
      model_reset();
      #1;
      vectors++;
      if (bus.grant !== 4'b0000 || bus.write !== 1'b0 || bus.ack !== 4'b0000) begin
         miscompares++;
         $display("FAIL async_reset_drop: grant=%b write=%b ack=%b want all zero", bus.grant, bus.write, bus.ack);
      end
      tick();
      rst = 1'b0;
      bus.req = 4'b1111;
      @(negedge clk);
      vectors++;
      if (bus.grant !== 4'b0000) begin
         miscompares++;
         $display("FAIL async_restart_idle: grant=%b want 0000", bus.grant);
      end
      tick();
      @(negedge clk);
      vectors++;
      if (bus.grant !== 4'b0001) begin
         miscompares++;
         $display("FAIL async_restart_grant: grant=%b want 0001", bus.grant);
      end
      tick();
   endtask

   task automatic test_random();
      do_reset();
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < N_REQ; i++) bus.req[i] = ($urandom_range(0, 9) < 7);
         bus.fifo_full = ($urandom_range(0, 3) == 0);
         rand_data();
         @(negedge clk);
         vectors++;
         if ({bus.grant, bus.ack, bus.write, bus.w_data, bus.busy} !== model_out()) begin
            miscompares++;
            $display("FAIL random cyc%0d: req=%b full=%b got %h want %h", c, bus.req, bus.fifo_full,
                     {bus.grant, bus.ack, bus.write, bus.w_data, bus.busy}, model_out());
         end
         vectors++;
         if ($countones(bus.ack) > 1 || (bus.write && bus.fifo_full) || (bus.write && bus.grant == '0)) begin
            miscompares++;
            $display("FAIL random_invariant cyc%0d: ack=%b write=%b full=%b grant=%b", c, bus.ack, bus.write, bus.fifo_full, bus.grant);
         end
         tick();
      end
   endtask

   initial begin
      rst = 1'b1;
      bus.req = '0;
      bus.req_data = '0;
      bus.fifo_full = 1'b0;
      model_reset();
      test_reset();
      test_single_stream();
      test_round_robin();
      test_early_release();
      test_full_stall();
      test_async_reset();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
